// File: rtl/arbitro_vc_if.sv
// -----------------------------------------------------------------------------
// arbitro_vc_if
//   Bundles the source (VC0/VC1) and destination (D0/D1) FIFO signals of the
//   VC arbiter.
//   master : the arbiter. It reads the FIFO flags and head words, and drives
//            the pop strobes, the push strobes and d_data.
//   slave  : the FIFO side. It drives the flags and head words, and receives
//            the strobes.
//   Signals:
//     vc0_empty, vc1_empty         source FIFO empty flags
//     vc0_data,  vc1_data          source head words (first-word-fall-through)
//     vc0_pop,   vc1_pop           combinational pop strobes
//     d0_almost_full, d1_almost_full  destination back-pressure
//     d0_push,   d1_push           registered push strobes
//     d_data                       registered word presented to D0/D1
// -----------------------------------------------------------------------------
interface arbitro_vc_if #(
  parameter int DATA_WIDTH = 6
);
  logic                  vc0_empty;
  logic                  vc1_empty;
  logic [DATA_WIDTH-1:0] vc0_data;
  logic [DATA_WIDTH-1:0] vc1_data;
  logic                  vc0_pop;
  logic                  vc1_pop;
  logic                  d0_almost_full;
  logic                  d1_almost_full;
  logic                  d0_push;
  logic                  d1_push;
  logic [DATA_WIDTH-1:0] d_data;

  modport master (
    input  vc0_empty, vc1_empty, vc0_data, vc1_data,
    input  d0_almost_full, d1_almost_full,
    output vc0_pop, vc1_pop, d0_push, d1_push, d_data
  );

  modport slave (
    output vc0_empty, vc1_empty, vc0_data, vc1_data,
    output d0_almost_full, d1_almost_full,
    input  vc0_pop, vc1_pop, d0_push, d1_push, d_data
  );
endinterface

// File: rtl/arbitro_vc.sv
// -----------------------------------------------------------------------------
// arbitro_vc
//   Moves words from two virtual-channel FIFOs (VC0, VC1) into two destination
//   FIFOs (D0, D1). Each cycle at most one eligible VC head is popped. The word
//   is pushed one cycle later into the destination that its routing bit
//   selects. VC0 has strict priority. When the macro ARB_FAIRNESS_EN is
//   defined, a starvation counter forces one VC1 grant after STARVE_LIMIT
//   consecutive VC0 grants that were made while VC1 was waiting.
//
//   Parameters:
//     DATA_WIDTH    word width
//     DEST_BIT      routing bit index (0 -> D0, 1 -> D1)
//     STARVE_LIMIT  VC0 grants tolerated while VC1 waits (1..15, fairness only)
//   Ports:
//     clk         clock, rising edge
//     reset       asynchronous, active-low reset
//     enable      1 permits new grants
//     bus         arbitro_vc_if.master: FIFO flags, head words and strobes
//     grant       registered last grant: 00 none, 01 VC0, 10 VC1
//     starve_cnt  fairness counter, constant 0 without ARB_FAIRNESS_EN
//   Build option: `define ARB_FAIRNESS_EN enables the anti-starvation counter.
// -----------------------------------------------------------------------------
module arbitro_vc #(
  parameter int DATA_WIDTH   = 6,
  parameter int DEST_BIT     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  arbitro_vc_if.master        bus,
  output logic [1:0]          grant,
  output logic [3:0]          starve_cnt
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("arbitro_vc: STARVE_LIMIT must be in 1..15");
  end
  if (DEST_BIT < 0 || DEST_BIT >= DATA_WIDTH) begin : g_bad_dest
    $error("arbitro_vc: DEST_BIT must index into the data word");
  end

  // The grant register is the FSM state. The encoding equals the grant output.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SERVE_VC0 = 2'b01,
    SERVE_VC1 = 2'b10
  } state_e;

  state_e                state_q, state_d;
  logic                  elig0, elig1, force_vc1;
  logic                  pop0, pop1;
  logic [DATA_WIDTH-1:0] sel_word;
  logic [DATA_WIDTH-1:0] d_data_q;
  logic                  d0_push_q, d1_push_q;
  logic [3:0]            starve_q;

  // A VC is eligible when its head word can be accepted by the destination
  // that the word routes to. A blocked destination stalls only that VC.
  // Gating with reset keeps the pops low while reset is held.
  assign elig0 = enable & reset & ~bus.vc0_empty &
                 ~(bus.vc0_data[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full);
  assign elig1 = enable & reset & ~bus.vc1_empty &
                 ~(bus.vc1_data[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full);

  // Selection is the next state. Any state can reach any state in one cycle.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // that no path leaves a signal unassigned and no latch is inferred.
    state_d  = IDLE;
    pop0     = 1'b0;
    pop1     = 1'b0;
    sel_word = bus.vc0_data;
    if (force_vc1) begin
      state_d  = SERVE_VC1;
      pop1     = 1'b1;
      sel_word = bus.vc1_data;
    end else if (elig0) begin
      state_d  = SERVE_VC0;
      pop0     = 1'b1;
      sel_word = bus.vc0_data;
    end else if (elig1) begin
      state_d  = SERVE_VC1;
      pop1     = 1'b1;
      sel_word = bus.vc1_data;
    end
  end

  // NOTE: sequential state always uses non-blocking assignments, so every flop
  // samples values from before the clock edge regardless of process order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // One word is in flight. It is captured on the pop edge and pushed in the
  // next cycle. The asynchronous reset discards the in-flight word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: d_data is a single output register, not a storage array, so it
      // is cheap to reset and its reset value is observable.
      d_data_q  <= '0;
      d0_push_q <= 1'b0;
      d1_push_q <= 1'b0;
    end else if (pop0 || pop1) begin
      d_data_q  <= sel_word;
      d0_push_q <= ~sel_word[DEST_BIT];
      d1_push_q <=  sel_word[DEST_BIT];
    end else begin
      d0_push_q <= 1'b0;
      d1_push_q <= 1'b0;
    end
  end

`ifdef ARB_FAIRNESS_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // At the limit, VC1 wins once over a competing VC0.
  assign force_vc1 = elig1 & (starve_q == LIMIT);

  // Counts VC0 grants that VC1 lost while waiting. A VC1 grant clears the
  // count, and the count saturates at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else if (pop1) begin
      starve_q <= '0;
    end else if (pop0 && elig1 && (starve_q != LIMIT)) begin
      starve_q <= starve_q + 4'd1;
    end
  end
`else
  assign force_vc1 = 1'b0;
  assign starve_q  = '0;
`endif

  assign bus.vc0_pop = pop0;
  assign bus.vc1_pop = pop1;
  assign bus.d0_push = d0_push_q;
  assign bus.d1_push = d1_push_q;
  assign bus.d_data  = d_data_q;
  assign grant       = state_q;
  assign starve_cnt  = starve_q;

endmodule

// File: tb/tb_arbitro_vc.sv
// -----------------------------------------------------------------------------
// tb_arbitro_vc
//   Bench for arbitro_vc. The bench plays both VC FIFOs with queues. A
//   reference model derives the expected pops, pushes, grant and starvation
//   count from the eligibility and priority rules. A compare process checks
//   the DUT against the model on every falling edge. Directed scenarios add
//   literal expectations that pin the model itself.
// -----------------------------------------------------------------------------
module tb_arbitro_vc;
  localparam int DW = 6;
  localparam int DB = 4;
  localparam int SL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] grant;
  logic [3:0] starve_cnt;

  arbitro_vc_if #(.DATA_WIDTH(DW)) bus ();

  arbitro_vc #(
    .DATA_WIDTH  (DW),
    .DEST_BIT    (DB),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .bus       (bus),
    .grant     (grant),
    .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  // Source FIFO contents. Element 0 is the head word.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  // Reference model state: what the registered outputs must show.
  logic          m_push0, m_push1;
  logic [DW-1:0] m_data;
  logic [1:0]    m_grant;
  int            m_starve;
  logic [1:0]    last_sel;
  bit            chk_en = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // A head word is eligible if it exists and its destination has room.
  function automatic bit eligible(input bit empty, input logic [DW-1:0] word);
    bit blocked;
    blocked = word[DB] ? bus.d1_almost_full : bus.d0_almost_full;
    return reset && enable && !empty && !blocked;
  endfunction

  // Winner for the current inputs: 0 none, 1 VC0, 2 VC1.
  function automatic logic [1:0] model_sel();
    bit e0, e1;
    e0 = eligible(bus.vc0_empty, bus.vc0_data);
    e1 = eligible(bus.vc1_empty, bus.vc1_data);
`ifdef ARB_FAIRNESS_EN
    if (e1 && m_starve == SL) return 2'd2;
`endif
    if (e0) return 2'd1;
    if (e1) return 2'd2;
    return 2'd0;
  endfunction

  // Model update on the rising edge.
  task automatic model_clock();
    logic [DW-1:0] w;
    bit            e1;
    last_sel = 2'd0;
    if (!reset) return;
    e1       = eligible(bus.vc1_empty, bus.vc1_data);
    last_sel = model_sel();
    m_grant  = last_sel;
    if (last_sel == 2'd0) begin
      m_push0 = 1'b0;
      m_push1 = 1'b0;
    end else begin
      w       = (last_sel == 2'd1) ? bus.vc0_data : bus.vc1_data;
      m_data  = w;
      m_push1 = w[DB];
      m_push0 = !w[DB];
    end
`ifdef ARB_FAIRNESS_EN
    if (last_sel == 2'd2) m_starve = 0;
    else if (last_sel == 2'd1 && e1 && m_starve < SL) m_starve++;
`endif
  endtask

  task automatic refresh();
    bus.vc0_empty = (q0.size() == 0);
    bus.vc0_data  = (q0.size() == 0) ? '0 : q0[0];
    bus.vc1_empty = (q1.size() == 0);
    bus.vc1_data  = (q1.size() == 0) ? '0 : q1[0];
  endtask

  // One clock: the model follows the edge, then the FIFOs advance just after it.
  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
    if (last_sel == 2'd1) void'(q0.pop_front());
    else if (last_sel == 2'd2) void'(q1.pop_front());
    refresh();
  endtask

  task automatic set_reset(input bit v);
    reset = v;
    if (!v) begin
      m_push0  = 1'b0;
      m_push1  = 1'b0;
      m_data   = '0;
      m_grant  = 2'd0;
      m_starve = 0;
    end
  endtask

  // Compare process: runs on every falling edge.
  logic [1:0] cmp_sel;
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_sel = model_sel();
      check("vc0_pop",    32'(bus.vc0_pop), 32'(cmp_sel == 2'd1));
      check("vc1_pop",    32'(bus.vc1_pop), 32'(cmp_sel == 2'd2));
      check("d0_push",    32'(bus.d0_push), 32'(m_push0));
      check("d1_push",    32'(bus.d1_push), 32'(m_push1));
      check("d_data",     32'(bus.d_data),  32'(m_data));
      check("grant",      32'(grant),       32'(m_grant));
      check("starve_cnt", 32'(starve_cnt),  32'(m_starve));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    enable             = 1'b1;
    bus.d0_almost_full = 1'b0;
    bus.d1_almost_full = 1'b0;
    set_reset(1'b0);
    q0 = {6'h13};
    q1 = {6'h25};
    refresh();
    chk_en = 1'b1;

    // Reset is held with both VCs non-empty: everything must stay quiet.
    @(negedge clk);
    check("rst_vc0_pop", 32'(bus.vc0_pop), 32'h0);
    check("rst_vc1_pop", 32'(bus.vc1_pop), 32'h0);
    check("rst_grant",   32'(grant),       32'h0);
    check("rst_d_data",  32'(bus.d_data),  32'h0);
    check("rst_push",    32'({bus.d0_push, bus.d1_push}), 32'h0);
    tick();
    tick();
    set_reset(1'b1);
    @(negedge clk);
    check("first_pop_vc0", 32'(bus.vc0_pop), 32'h1);
    tick();
    // 6'b010011 has bit 4 set, so it goes to D1. VC1 is served next.
    @(negedge clk);
    check("w13_d1_push", 32'(bus.d1_push), 32'h1);
    check("w13_d0_push", 32'(bus.d0_push), 32'h0);
    check("w13_d_data",  32'(bus.d_data),  32'h13);
    check("w13_grant",   32'(grant),       32'h1);
    check("vc1_next",    32'(bus.vc1_pop), 32'h1);
    tick();
    @(negedge clk);
    check("w25_d0_push", 32'(bus.d0_push), 32'h1);
    check("w25_d_data",  32'(bus.d_data),  32'h25);
    check("w25_grant",   32'(grant),       32'h2);
    tick();
    check("both_empty_idle", 32'(grant), 32'h0);

    // Head-of-line: VC0 is routed to a full D0, so VC1 goes ahead to D1.
    bus.d0_almost_full = 1'b1;
    q0.push_back(6'h05);
    q1.push_back(6'h31);
    refresh();
    @(negedge clk);
    check("hol_vc1_pop", 32'(bus.vc1_pop), 32'h1);
    check("hol_vc0_pop", 32'(bus.vc0_pop), 32'h0);
    tick();
    check("hol_grant", 32'(grant), 32'h2);
    bus.d0_almost_full = 1'b0;
    @(negedge clk);
    check("hol_resume", 32'(bus.vc0_pop), 32'h1);
    tick();
    @(negedge clk);
    check("w05_d0_push", 32'(bus.d0_push), 32'h1);
    check("w05_d_data",  32'(bus.d_data),  32'h05);
    tick();

    // Both heads route to a full D1: nothing moves.
    bus.d1_almost_full = 1'b1;
    q0.push_back(6'h12);
    q1.push_back(6'h1F);
    refresh();
    @(negedge clk);
    check("same_dest_pops", 32'({bus.vc0_pop, bus.vc1_pop}), 32'h0);
    tick();
    check("same_dest_idle", 32'(grant), 32'h0);
    bus.d1_almost_full = 1'b0;
    tick();
    tick();
    tick();

    // Both VCs stay eligible: strict priority, or the fairness pattern.
    for (int i = 0; i < 10; i++) q0.push_back(DW'(i * 5 + 2));
    q1.push_back(6'h3C);
    q1.push_back(6'h0A);
    q1.push_back(6'h1B);
    refresh();
    tick();
    tick();
    tick();
    tick();
    @(negedge clk);
    check("stream_grant4", 32'(grant), 32'h1);
`ifdef ARB_FAIRNESS_EN
    check("stream_starve4", 32'(starve_cnt), 32'h4);
    check("stream_vc1_forced", 32'(bus.vc1_pop), 32'h1);
`else
    check("stream_starve0", 32'(starve_cnt), 32'h0);
    check("stream_vc0_again", 32'(bus.vc0_pop), 32'h1);
`endif
    for (int i = 0; i < 10; i++) tick();

    // enable falls right after a pop: that word is still pushed.
    q0.push_back(6'h13);
    q0.push_back(6'h05);
    refresh();
    tick();
    enable = 1'b0;
    @(negedge clk);
    check("en_low_push",   32'(bus.d1_push), 32'h1);
    check("en_low_data",   32'(bus.d_data),  32'h13);
    check("en_low_no_pop", 32'(bus.vc0_pop), 32'h0);
    tick();
    @(negedge clk);
    check("en_low_quiet", 32'({bus.d0_push, bus.d1_push}), 32'h0);
    tick();
    enable = 1'b1;
    @(negedge clk);
    check("en_rise_pop", 32'(bus.vc0_pop), 32'h1);
    tick();

    // reset is pulsed while a word is in flight: the push is dropped.
    q0.push_back(6'h33);
    refresh();
    tick();
    set_reset(1'b0);
    @(negedge clk);
    check("rst_mid_push",  32'(bus.d1_push), 32'h0);
    check("rst_mid_grant", 32'(grant),       32'h0);
    check("rst_mid_data",  32'(bus.d_data),  32'h0);
    tick();
    set_reset(1'b1);
    @(negedge clk);
    check("post_rst_idle", 32'({bus.vc0_pop, bus.vc1_pop}), 32'h0);
    tick();
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arbitro_vc.md
# arbitro_vc

Arbiter between the VC0 and VC1 virtual-channel FIFOs and the D0/D1 destination FIFOs. Each cycle it picks at most one eligible VC head word, pops it and pushes it one cycle later into the destination FIFO selected by a routing bit. Arbitration is strict VC0 priority, optionally bounded by an anti-starvation counter. It sits downstream of the control FSM, which enables it through `enable` (driven from the FSM's active output).

## Interface
- DATA_WIDTH, 6, word width of VC and D FIFOs
- DEST_BIT, 4, bit index of the routing bit in the word: 0 routes to D0, 1 routes to D1
- STARVE_LIMIT, 4, consecutive VC0 grants tolerated while VC1 is eligible (fairness build only); legal range 1..15
- clk  in  1  clock, all state updates on posedge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- enable  in  1  1 permits new grants
- vc0_empty, vc1_empty  in  1 each  source FIFO empty flags
- vc0_data, vc1_data  in  DATA_WIDTH each  source head word, first-word-fall-through, valid while not empty
- d0_almost_full, d1_almost_full  in  1 each  destination back-pressure
- vc0_pop, vc1_pop  out  1 each  combinational pop strobes
- d0_push, d1_push  out  1 each  registered push strobes
- d_data  out  DATA_WIDTH  registered word presented to D0/D1
- grant  out  2  registered last grant: 00 none, 01 VC0, 10 VC1
- starve_cnt  out  4  fairness counter; constant 0 when the feature is compiled out

## Operation
- Eligibility, combinational:
  - eligX = enable & reset & !vcX_empty & !dY_almost_full, where Y = vcX_data[DEST_BIT].
- Selection:
  - VC0 wins if elig0.
  - VC1 wins if elig1 & !elig0.
  - With fairness compiled in, VC1 wins if elig1 & (starve_cnt == STARVE_LIMIT), whether or not elig0.
- Only the winner's pop is asserted, so vc0_pop and vc1_pop are never both 1.
- On a pop cycle, the flops capture the selected word into d_data and set dY_push = 1 for Y = word[DEST_BIT]; the other push is 0.
- Cycles with no pop: both pushes go to 0 and d_data holds its value.
- FSM state is the `grant` register, with states IDLE (00), SERVE_VC0 (01) and SERVE_VC1 (10). The next state equals the current cycle's selection, so any state moves to any state in one cycle.
- Reset values: vc*_pop = 0 (gated by reset), d0_push = d1_push = 0, d_data = 0, grant = IDLE, starve_cnt = 0.
- Boundary conditions:
  - Both VCs empty: IDLE, no strobes.
  - Destination almost_full: a head word routed there stalls its VC only. The other VC may proceed (no head-of-line blocking across VCs).
  - Both VCs' heads routed to the same full destination: IDLE.
  - enable falls mid-stream: no pop in that cycle. A word popped in the previous cycle is still pushed.
  - enable rises: first pop in the same cycle, if a VC is eligible.
  - reset asserted mid-transfer: the in-flight word is discarded and the push is cleared asynchronously.
  - almost_full must assert with at least one free entry; the arbiter relies on this for its single in-flight word.

## Timing
- Pop to push latency is 1 cycle. Pop at edge N gives push and d_data valid after edge N+1 ... i.e. in cycle N+1.
- Throughput is one word per cycle sustained.
- almost_full is sampled combinationally in the pop cycle. A flag rising in cycle N blocks pops in cycle N.
- A pop is consumed at the posedge where vcX_pop = 1. The FIFO presents the next head word in the following cycle.

## Configuration
- ARB_FAIRNESS_EN defined:
  - starve_cnt increments on each VC0 grant made while elig1 = 1.
  - It clears to 0 on a VC1 grant.
  - It holds otherwise, saturating at STARVE_LIMIT.
  - At the limit, VC1 is forced to win once.
- ARB_FAIRNESS_EN undefined:
  - Pure strict VC0 priority; VC1 can starve indefinitely.
  - starve_cnt is tied to 0.

## Test plan
- Reset low with both VCs non-empty and enable = 1 -> all pops and pushes 0, grant = 00, d_data = 0. Release reset -> vc0_pop = 1 in the first cycle.
- VC0 head 6'b010011 (bit4 = 1), VC1 empty, D1 not full -> vc0_pop for 1 cycle, next cycle d1_push = 1 and d_data = 6'b010011, d0_push = 0.
- VC0 head routed to D0 with d0_almost_full = 1, VC1 head routed to D1 -> vc1_pop = 1, vc0_pop = 0, grant = 10. Drop almost_full -> VC0 resumes next cycle.
- Fairness build, STARVE_LIMIT = 4, both VCs continuously eligible -> grant pattern VC0 ×4, VC1 ×1, repeating, with starve_cnt 1,2,3,4,0. Non-fairness build -> VC0 only.
- enable falls the cycle after a pop -> that word is still pushed and no further pops occur. reset pulsed the cycle after a pop -> push suppressed, grant = 00.
